// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a START/BUSY/DONE handshake.
// Operands are widened by one bit so that one datapath handles both signed
// and unsigned multiplies. One Booth step runs per clock, so an operation
// takes WIDTH+1 steps. All outputs come straight from registers.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   M1,
  input  logic [WIDTH-1:0]   M2,
  input  logic               SIGNED_MODE,
  output logic [2*WIDTH-1:0] out,
  output logic               BUSY,
  output logic               DONE
);

  // The counter is wide enough to hold the index of the final step (WIDTH).
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_r, state_next_s;

  // Widen an operand to WIDTH+1 bits. Signed operands are sign-extended and
  // unsigned operands are zero-extended.
  function automatic logic [WIDTH:0] extend_op(input logic [WIDTH-1:0] op, input logic sgn);
    extend_op = {sgn & op[WIDTH-1], op};
  endfunction

  logic [WIDTH+1:0]   mx_r;
  logic [WIDTH+1:0]   a_r;
  logic [WIDTH:0]     q_r;
  logic               q1_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] out_r;
  logic               busy_r;
  logic               done_r;

  logic [WIDTH:0]     m1_ext_s;
  logic [WIDTH:0]     m2_ext_s;
  logic [WIDTH+1:0]   sum_s;
  logic [WIDTH+1:0]   a_shift_s;
  logic [WIDTH:0]     q_shift_s;
  logic               q1_shift_s;
  logic [2*WIDTH-1:0] product_s;
  logic               accept_s;
  logic               last_step_s;

  assign m1_ext_s    = extend_op(M1, SIGNED_MODE);
  assign m2_ext_s    = extend_op(M2, SIGNED_MODE);
  assign accept_s    = (state_r == IDLE) && START;
  assign last_step_s = (state_r == RUN) && (cnt_r == LAST_STEP);

  // One Booth step: add or subtract Mx, then shift {A, Q, q_1} right arithmetically.
  always_comb begin
    sum_s = a_r;
    case ({q_r[0], q1_r})
      2'b01:   sum_s = a_r + mx_r;
      2'b10:   sum_s = a_r - mx_r;
      default: sum_s = a_r;
    endcase
    a_shift_s  = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
    q_shift_s  = {sum_s[0], q_r[WIDTH:1]};
    q1_shift_s = q_r[0];
    // The upper bits of A only repeat the sign, so the low 2*WIDTH bits give the exact product.
    product_s  = {a_shift_s[WIDTH-2:0], q_shift_s};
  end

  // Next-state logic: start on an accepted request, and finish after the final step.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (START) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers: load the operands on accept, then run one step per cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      mx_r  <= {(WIDTH+2){1'b0}};
      a_r   <= {(WIDTH+2){1'b0}};
      q_r   <= {(WIDTH+1){1'b0}};
      q1_r  <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      mx_r  <= {m1_ext_s[WIDTH], m1_ext_s};
      a_r   <= {(WIDTH+2){1'b0}};
      q_r   <= m2_ext_s;
      q1_r  <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      a_r   <= a_shift_s;
      q_r   <= q_shift_s;
      q1_r  <= q1_shift_s;
      cnt_r <= cnt_r + CW'(1);
    end else begin
      a_r   <= a_r;
      q_r   <= q_r;
      q1_r  <= q1_r;
      cnt_r <= cnt_r;
    end
  end

  // Output registers: hold the product until the next completion and pulse DONE for one cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      out_r  <= {(2*WIDTH){1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= last_step_s;
      if (last_step_s) begin
        out_r <= product_s;
      end else begin
        out_r <= out_r;
      end
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (last_step_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign out  = out_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq with WIDTH=8 and WIDTH=16 instances,
// plus a randomized pass on the 16-bit instance.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  m1_8, m2_8;
  logic [15:0] out8;
  logic        start16, sm16, busy16, done16;
  logic [15:0] m1_16, m2_16;
  logic [31:0] out16;

  int n_checks = 0;
  int n_errors = 0;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .RST(rst), .START(start8), .M1(m1_8), .M2(m2_8),
    .SIGNED_MODE(sm8), .out(out8), .BUSY(busy8), .DONE(done8)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .RST(rst), .START(start16), .M1(m1_16), .M2(m2_16),
    .SIGNED_MODE(sm16), .out(out16), .BUSY(busy16), .DONE(done16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one 8-bit multiply with START pulsed for one cycle, then check latency, BUSY and the product.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                     input logic [15:0] exp, input string tag);
    int k;
    int busy_n;
    @(negedge clk);
    m1_8 = a; m2_8 = b; sm8 = sm; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 0; busy_n = 0;
    while (!done8 && k < 40) begin
      if (busy8) busy_n++;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, 9);
    check({tag, "_busy_cycles"}, busy_n, 9);
    check({tag, "_busy_at_done"}, {31'd0, busy8}, 32'd0);
    check({tag, "_out"}, {16'd0, out8}, {16'd0, exp});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done8}, 32'd0);
  endtask

  initial begin
    int k, nd, kd, k1, k2;
    logic [15:0] od;
    logic [31:0] o1, o2, exp32;
    logic [15:0] ra, rb;

    rst = 1'b1;
    start8 = 1'b0; m1_8 = 8'd0; m2_8 = 8'd0; sm8 = 1'b0;
    start16 = 1'b0; m1_16 = 16'd0; m2_16 = 16'd0; sm16 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out8", {16'd0, out8}, 32'd0);
    check("reset_busy8", {31'd0, busy8}, 32'd0);
    check("reset_done8", {31'd0, done8}, 32'd0);
    check("reset_out16", out16, 32'd0);
    check("reset_busy16", {31'd0, busy16}, 32'd0);
    rst = 1'b0;

    // Basic unsigned case, then the signed and unsigned boundary sweeps.
    op8(8'h04, 8'h04, 1'b0, 16'h0010, "u_4x4");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_80x80");
    op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_FFx01");
    op8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_7Fx80");
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_FFxFF");
    op8(8'hFF, 8'h01, 1'b0, 16'h00FF, "u_FFx01");
    op8(8'h00, 8'h9C, 1'b1, 16'h0000, "s_00x9C");

    // A second START raised during RUN must be ignored.
    @(negedge clk);
    m1_8 = 8'h03; m2_8 = 8'h05; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nd = 0; kd = -1; od = 16'd0;
    for (int i = 0; i < 24; i++) begin
      if (done8) begin nd++; kd = i; od = out8; end
      if (i == 2) begin
        start8 = 1'b1; m1_8 = 8'h0A; m2_8 = 8'h0A;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_prot_done_count", nd, 1);
    check("busy_prot_done_cycle", kd, 9);
    check("busy_prot_out", {16'd0, od}, 32'h0000000F);

    // Reset in the middle of an operation aborts it without a DONE.
    @(negedge clk);
    m1_8 = 8'h12; m2_8 = 8'h34; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", {16'd0, out8}, 32'd0);
    check("midrst_busy", {31'd0, busy8}, 32'd0);
    check("midrst_done", {31'd0, done8}, 32'd0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      if (done8) nd++;
      @(negedge clk);
    end
    check("midrst_no_done", nd, 0);
    op8(8'h02, 8'h03, 1'b0, 16'h0006, "post_reset");

    // Back-to-back on the 16-bit instance with START held through DONE.
    @(negedge clk);
    m1_16 = 16'h8000; m2_16 = 16'h7FFF; sm16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    m1_16 = 16'hFFFF; m2_16 = 16'hFFFF; sm16 = 1'b0;
    nd = 0; k1 = -1; k2 = -1; o1 = 32'd0; o2 = 32'd0;
    for (int i = 0; i < 45; i++) begin
      if (done16) begin
        if (nd == 0) begin
          k1 = i; o1 = out16;
        end else begin
          k2 = i; o2 = out16; start16 = 1'b0;
        end
        nd++;
      end
      @(negedge clk);
    end
    start16 = 1'b0;
    check("b2b_first_cycle", k1, 17);
    check("b2b_first_out", o1, 32'hC0008000);
    check("b2b_second_cycle", k2, 35);
    check("b2b_second_out", o2, 32'hFFFE0001);
    check("b2b_done_count", nd, 2);

    // Randomized regression against a behavioural product, both modes.
    for (int mode = 0; mode < 2; mode++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (mode == 1) begin
          exp32 = 32'(longint'($signed(ra)) * longint'($signed(rb)));
        end else begin
          exp32 = 32'(longint'(ra) * longint'(rb));
        end
        @(negedge clk);
        m1_16 = ra; m2_16 = rb; sm16 = (mode == 1); start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        k = 0;
        while (!done16 && k < 40) begin
          @(negedge clk);
          k++;
        end
        if (k != 17) check("rand_latency", k, 17);
        check(mode == 1 ? "rand_signed" : "rand_unsigned", out16, exp32);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier, successor to the fixed 8-bit Booth_Multiplier. It multiplies two WIDTH-bit operands in either signed (two's complement) or unsigned mode, selected per operation, and produces a 2·WIDTH-bit product. It uses an explicit START/BUSY/DONE handshake so a controller or datapath sequencer can issue back-to-back multiplies. Each operation has a fixed latency of WIDTH+1 cycles.

## Interface
- WIDTH, 8, operand width in bits (legal: 2..32)
- clk  input  1  rising-edge clock
- RST  input  1  synchronous reset, active-high
- START  input  1  request; sampled only when BUSY=0
- M1  input  WIDTH  multiplicand; captured on the accepting edge
- M2  input  WIDTH  multiplier; captured on the accepting edge
- SIGNED_MODE  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands
- out  output  2·WIDTH  product of the last completed operation; held until next completion
- BUSY  output  1  high while an operation is in progress
- DONE  output  1  one-cycle pulse; out is valid and new in that cycle

## Operation
- States: IDLE, RUN. DONE is a registered flag, not a state.
- IDLE: when START=1 at a rising edge, the block does the following:
  - Extends M1 and M2 to WIDTH+1 bits (sign-extend if SIGNED_MODE=1, zero-extend otherwise).
  - Loads multiplicand register Mx (WIDTH+2 bits, sign-extended from the WIDTH+1 value).
  - Loads Q = extended M2, A = 0 (WIDTH+2 bits), q_1 = 0, step counter = 0.
  - Sets BUSY=1 and enters RUN.
- RUN, one Booth step per edge:
  - {Q[0], q_1}=01: A = A + Mx.
  - {Q[0], q_1}=10: A = A − Mx.
  - 00 or 11: no add.
  - Then arithmetic-shift {A, Q, q_1} right by one; A's MSB replicates.
  - Counter increments.
- After step WIDTH+1, on the same edge:
  - out = low 2·WIDTH bits of {A, Q} after the final shift.
  - DONE=1, BUSY=0, state goes to IDLE.
- Width rule: A is WIDTH+2 bits, so A − Mx never overflows, including Mx = most-negative value. The true product always fits in 2·WIDTH bits in both modes, so truncation is exact.
- START while BUSY=1 is ignored: no queueing and no effect on the running operation. Operand and mode changes during RUN are also ignored.
- RST=1 at any edge:
  - State goes to IDLE; out=0, BUSY=0, DONE=0; internal registers are cleared.
  - An in-flight operation is aborted and never produces DONE.
  - RST takes priority over START on the same edge.

## Timing
- Reset values: out=0, BUSY=0, DONE=0.
- Accepting edge E0 (IDLE, START=1). BUSY=1 from E0 until E(WIDTH+1).
- Steps occur on E1..E(WIDTH+1). out and DONE update at E(WIDTH+1).
- Latency is WIDTH+1 cycles from the accepting edge to DONE (9 cycles for WIDTH=8).
- DONE is high for exactly one cycle and deasserts at E(WIDTH+2) unless a new operation completes then (impossible for WIDTH≥1).
- Back-to-back: START=1 during the DONE cycle is accepted at E(WIDTH+2), giving one operation per WIDTH+2 cycles. The old out is held until the next DONE.
- START held high continuously produces repeated operations at that same rate.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, unsigned, M1=0x04, M2=0x04, START pulsed one cycle -> BUSY high 9 cycles, DONE pulse at E9, out=0x0010.
- WIDTH=8, signed, operand sweep:
  - 0x80×0x80 -> 0x4000
  - 0xFF×0x01 -> 0xFFFF
  - 0x7F×0x80 -> 0xC080
- WIDTH=8, unsigned, operand sweep:
  - 0xFF×0xFF -> 0xFE01
  - 0xFF×0x01 -> 0x00FF
- Busy protection: start 0x03×0x05; at E3 assert START with 0x0A×0x0A -> second request ignored, single DONE with out=0x000F.
- Reset mid-operation: start 0x12×0x34, assert RST at E4 -> out=0, BUSY=0, no DONE. A later 0x02×0x03 gives out=0x0006 after 9 cycles.
- Back-to-back with WIDTH=16 instance:
  - Signed 0x8000×0x7FFF -> 0xC0008000.
  - START held through DONE, next op unsigned 0xFFFF×0xFFFF -> 0xFFFE0001 exactly 18 cycles later.
  - Random regression of 1000 ops per mode compared against a reference model.
